// File: rtl/univ_shift_reg_en_amisha.sv
// rtl/univ_shift_reg_en_amisha.sv - universal enabled shift register with burst-shift FSM
//
// Purpose: WIDTH-bit register with synchronous active-high reset, global enable,
// single-cycle load/shift/rotate modes and an autonomous right-shift burst.
//
// Ports:
//   clk_amisha        in   clock, rising edge
//   reset_amisha      in   synchronous active-high reset, highest priority
//   en_amisha         in   global enable; low holds all state
//   mode_amisha       in   [2:0] operation select
//   d_amisha          in   [WIDTH-1:0] parallel load data
//   sin_amisha        in   serial input for shifts
//   burst_len_amisha  in   [CNT_W-1:0] number of right shifts in a burst
//   q_amisha          out  [WIDTH-1:0] register contents
//   sout_l_amisha     out  q_amisha[WIDTH-1]
//   sout_r_amisha     out  q_amisha[0]
//   busy_amisha       out  high while the FSM is in BURST
//   done_amisha       out  one-cycle pulse on burst completion

module univ_shift_reg_en_amisha #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           CNT_W     = 4
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             en_amisha,
  input  logic [2:0]       mode_amisha,
  input  logic [WIDTH-1:0] d_amisha,
  input  logic             sin_amisha,
  input  logic [CNT_W-1:0] burst_len_amisha,
  output logic [WIDTH-1:0] q_amisha,
  output logic             sout_l_amisha,
  output logic             sout_r_amisha,
  output logic             busy_amisha,
  output logic             done_amisha
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_BURST = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  state_t           state_q, state_d;

  // Next-state logic. With en low everything holds and done is forced low.
  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;

    if (en_amisha) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (mode_amisha)
            M_HOLD:  q_d = q_q;
            M_LOAD:  q_d = d_amisha;
            M_SHL:   q_d = {q_q[WIDTH-2:0], sin_amisha};
            M_SHR:   q_d = {sin_amisha, q_q[WIDTH-1:1]};
            M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            M_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            M_BURST: begin
              // Start cycle never shifts; a zero-length burst completes at once.
              if (burst_len_amisha != CNT_ZERO) begin
                cnt_d   = burst_len_amisha;
                state_d = S_BURST;
              end else begin
                done_d  = 1'b1;
              end
            end
            default: q_d = q_q;
          endcase
        end
        S_BURST: begin
          q_d   = {sin_amisha, q_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_ONE;
          // Last shift: done is registered so it lines up with the final q.
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      q_q     <= RESET_VAL;
      cnt_q   <= CNT_ZERO;
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign q_amisha      = q_q;
  assign sout_l_amisha = q_q[WIDTH-1];
  assign sout_r_amisha = q_q[0];
  assign busy_amisha   = (state_q == S_BURST);
  assign done_amisha   = done_q;

endmodule
